// File: rtl/keycode_pkg.sv
// Shared HID keycode constants and jump state encoding for the keycode input path.
package keycode_pkg;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_ENTER = 8'h28;

  typedef enum logic [1:0] {
    J_IDLE,
    J_HOLD,
    J_LOCK
  } jump_state_t;

endpackage

// File: rtl/keycode_filter.sv
// Stability filter: a keycode is accepted only after it has been present for
// STABLE_CYCLES consecutive cycles; shorter-lived values never reach filt_code.
module keycode_filter
  import keycode_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] keycode,
  output logic [7:0] filt_code
);

  localparam int unsigned CntW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [7:0]      prev_q;
  logic [7:0]      filt_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            same;

  // Next count: restart on any change, otherwise count up and saturate.
  always_comb begin
    same  = (keycode == prev_q);
    cnt_d = '0;
    if (same) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Track previous input and latch the code once the count hits its ceiling.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      prev_q <= KC_NONE;
      cnt_q  <= '0;
      filt_q <= KC_NONE;
    end else begin
      prev_q <= keycode;
      cnt_q  <= cnt_d;
      if (same && (cnt_d == CntMax)) begin
        filt_q <= keycode;
      end
    end
  end

  assign filt_code = filt_q;

endmodule

// File: rtl/keycode_input_ctrl.sv
// Mario control front end: filters the raw keycode, decodes buttons, catches
// press edges between frames and runs the jump FSM; outputs move only on frame_tick.
module keycode_input_ctrl
  import keycode_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES   = 1024,
  parameter int unsigned MAX_JUMP_FRAMES = 16
) (
  input  logic                                   clk_clk,
  input  logic                                   reset_reset,
  input  logic [7:0]                             keycode,
  input  logic                                   frame_tick,
  output logic                                   btn_left,
  output logic                                   btn_right,
  output logic                                   btn_down,
  output logic                                   jump_start,
  output logic                                   jump_hold,
  output logic [$clog2(MAX_JUMP_FRAMES+1)-1:0]   jump_frames,
  output logic                                   pause_toggle,
  output logic                                   key_valid
);

  localparam int unsigned FW = $clog2(MAX_JUMP_FRAMES + 1);
  localparam logic [FW-1:0] FramesMax = FW'(MAX_JUMP_FRAMES);
  localparam logic [FW-1:0] FramesOne = FW'(1);

  logic [7:0] filt_code;

  keycode_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .keycode    (keycode),
    .filt_code  (filt_code)
  );

  logic dec_left, dec_right, dec_down, dec_jump, dec_pause;
  logic jump_rise, pause_rise, jump_edge, pause_edge;
  logic jump_prev_q, pause_prev_q, jump_edge_seen_q, pause_edge_seen_q;

  // Decode filtered code; edges seen this very cycle still count at a tick.
  always_comb begin
    dec_left   = (filt_code == KC_A);
    dec_right  = (filt_code == KC_D);
    dec_down   = (filt_code == KC_S);
    dec_jump   = (filt_code == KC_W) || (filt_code == KC_SPACE);
    dec_pause  = (filt_code == KC_ENTER);
    jump_rise  = dec_jump & ~jump_prev_q;
    pause_rise = dec_pause & ~pause_prev_q;
    jump_edge  = jump_edge_seen_q | jump_rise;
    pause_edge = pause_edge_seen_q | pause_rise;
  end

  // Sticky press-edge flags, consumed by each frame_tick.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      jump_prev_q       <= 1'b0;
      pause_prev_q      <= 1'b0;
      jump_edge_seen_q  <= 1'b0;
      pause_edge_seen_q <= 1'b0;
    end else begin
      jump_prev_q  <= dec_jump;
      pause_prev_q <= dec_pause;
      if (frame_tick) begin
        jump_edge_seen_q  <= 1'b0;
        pause_edge_seen_q <= 1'b0;
      end else begin
        jump_edge_seen_q  <= jump_edge;
        pause_edge_seen_q <= pause_edge;
      end
    end
  end

  jump_state_t state_q;
  logic          btn_left_q, btn_right_q, btn_down_q, key_valid_q;
  logic          jump_start_q, jump_hold_q, pause_toggle_q;
  logic [FW-1:0] jump_frames_q;

  // Jump FSM and frame-latched outputs, evaluated once per frame_tick.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= J_IDLE;
      btn_left_q     <= 1'b0;
      btn_right_q    <= 1'b0;
      btn_down_q     <= 1'b0;
      key_valid_q    <= 1'b0;
      jump_start_q   <= 1'b0;
      jump_hold_q    <= 1'b0;
      jump_frames_q  <= '0;
      pause_toggle_q <= 1'b0;
    end else if (frame_tick) begin
      btn_left_q     <= dec_left;
      btn_right_q    <= dec_right;
      btn_down_q     <= dec_down;
      key_valid_q    <= (filt_code != KC_NONE);
      pause_toggle_q <= pause_edge;
      jump_start_q   <= 1'b0;
      unique case (state_q)
        J_IDLE: begin
          if (dec_jump) begin
            state_q       <= J_HOLD;
            jump_start_q  <= 1'b1;
            jump_frames_q <= FramesOne;
            jump_hold_q   <= 1'b1;
          end else if (jump_edge) begin
            // Tap fully inside one frame: report the jump, nothing left to hold.
            jump_start_q  <= 1'b1;
            jump_frames_q <= FramesOne;
            jump_hold_q   <= 1'b0;
          end else begin
            jump_frames_q <= '0;
            jump_hold_q   <= 1'b0;
          end
        end
        J_HOLD: begin
          if (!dec_jump) begin
            state_q       <= J_IDLE;
            jump_frames_q <= '0;
            jump_hold_q   <= 1'b0;
          end else if (jump_frames_q == FramesMax - FramesOne) begin
            state_q       <= J_LOCK;
            jump_frames_q <= FramesMax;
            jump_hold_q   <= 1'b0;
          end else begin
            jump_frames_q <= jump_frames_q + FramesOne;
            jump_hold_q   <= 1'b1;
          end
        end
        J_LOCK: begin
          jump_hold_q <= 1'b0;
          if (!dec_jump) begin
            state_q       <= J_IDLE;
            jump_frames_q <= '0;
          end else begin
            jump_frames_q <= FramesMax;
          end
        end
        default: begin
          state_q       <= J_IDLE;
          jump_frames_q <= '0;
          jump_hold_q   <= 1'b0;
        end
      endcase
    end
  end

  assign btn_left     = btn_left_q;
  assign btn_right    = btn_right_q;
  assign btn_down     = btn_down_q;
  assign key_valid    = key_valid_q;
  assign jump_start   = jump_start_q;
  assign jump_hold    = jump_hold_q;
  assign jump_frames  = jump_frames_q;
  assign pause_toggle = pause_toggle_q;

endmodule

// File: tb/tb_keycode_input_ctrl.sv
// Scoreboard bench for keycode_input_ctrl: a behavioural model predicts the
// frame outputs at each tick; a monitor compares the DUT every cycle.
module tb_keycode_input_ctrl;

  localparam int unsigned S  = 4;
  localparam int unsigned M  = 16;
  localparam int unsigned FW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [7:0]    kc = 8'h00;
  logic          btn_left, btn_right, btn_down, jump_start, jump_hold, pause_toggle, key_valid;
  logic [FW-1:0] jump_frames;

  always #5 clk = ~clk;

  keycode_input_ctrl #(
    .STABLE_CYCLES  (S),
    .MAX_JUMP_FRAMES(M)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .keycode     (kc),
    .frame_tick  (tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_down    (btn_down),
    .jump_start  (jump_start),
    .jump_hold   (jump_hold),
    .jump_frames (jump_frames),
    .pause_toggle(pause_toggle),
    .key_valid   (key_valid)
  );

  typedef struct packed {
    logic          l, r, d, js, jh;
    logic [FW-1:0] jf;
    logic          pt, kv;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  exp_t m_out;
  bit   have_exp = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference model state: spec-level quantities only.
  logic [7:0] m_filt, m_filt_prev, run_val;
  int         run_len;
  bit         j_seen, p_seen, jd, jr, pr;
  int         m_state;  // 0 idle, 1 holding, 2 locked
  int         m_frames;

  function automatic bit is_jump(input logic [7:0] c);
    return (c == 8'h1A) || (c == 8'h2C);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_filt = 8'h00; m_filt_prev = 8'h00; run_val = 8'h00; run_len = 1;
      j_seen = 0; p_seen = 0; m_state = 0; m_frames = 0;
      m_out = '0;
      q.push_back(m_out);
    end else begin
      jd = is_jump(m_filt);
      jr = jd && !is_jump(m_filt_prev);
      pr = (m_filt == 8'h28) && (m_filt_prev != 8'h28);
      if (tick) begin
        m_out.l  = (m_filt == 8'h04);
        m_out.r  = (m_filt == 8'h07);
        m_out.d  = (m_filt == 8'h16);
        m_out.kv = (m_filt != 8'h00);
        m_out.pt = p_seen || pr;
        m_out.js = 1'b0;
        case (m_state)
          0: begin
            if (jd) begin
              m_state = 1; m_out.js = 1'b1; m_frames = 1; m_out.jh = 1'b1;
            end else if (j_seen || jr) begin
              m_out.js = 1'b1; m_frames = 1; m_out.jh = 1'b0;
            end else begin
              m_frames = 0; m_out.jh = 1'b0;
            end
          end
          1: begin
            if (jd) begin
              m_frames = m_frames + 1;
              if (m_frames == M) begin
                m_state = 2; m_out.jh = 1'b0;
              end else begin
                m_out.jh = 1'b1;
              end
            end else begin
              m_state = 0; m_frames = 0; m_out.jh = 1'b0;
            end
          end
          default: begin
            m_out.jh = 1'b0;
            if (!jd) begin
              m_state = 0; m_frames = 0;
            end
          end
        endcase
        m_out.jf = FW'(m_frames);
        q.push_back(m_out);
        j_seen = 0; p_seen = 0;
      end else begin
        j_seen = j_seen || jr;
        p_seen = p_seen || pr;
      end
      m_filt_prev = m_filt;
      if (kc == run_val) begin
        if (run_len < S) run_len = run_len + 1;
      end else begin
        run_val = kc; run_len = 1;
      end
      if (run_len >= S) m_filt = run_val;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs must match the last predicted frame on every cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      have_exp = 1;
    end
    if (have_exp) begin
      chk("btn_left", int'(btn_left), int'(cur.l));
      chk("btn_right", int'(btn_right), int'(cur.r));
      chk("btn_down", int'(btn_down), int'(cur.d));
      chk("jump_start", int'(jump_start), int'(cur.js));
      chk("jump_hold", int'(jump_hold), int'(cur.jh));
      chk("jump_frames", int'(jump_frames), int'(cur.jf));
      chk("pause_toggle", int'(pause_toggle), int'(cur.pt));
      chk("key_valid", int'(key_valid), int'(cur.kv));
      chk("left_right_exclusive", int'(btn_left && btn_right), 0);
    end
  end

  task automatic cyc(input logic [7:0] k, input logic t);
    kc = k;
    tick = t;
    @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] k, input int len);
    for (int i = 0; i < len - 1; i++) cyc(k, 1'b0);
    cyc(k, 1'b1);
  endtask

  logic [7:0] key_tab[8];
  logic [7:0] rk;

  initial begin
    key_tab[0] = 8'h00; key_tab[1] = 8'h04; key_tab[2] = 8'h07; key_tab[3] = 8'h16;
    key_tab[4] = 8'h1A; key_tab[5] = 8'h2C; key_tab[6] = 8'h28; key_tab[7] = 8'h33;
    rst = 1'b1;
    repeat (3) cyc(8'h00, 1'b0);
    rst = 1'b0;
    frame(8'h00, 8);

    // Tap between two ticks.
    repeat (10) cyc(8'h2C, 1'b0);
    frame(8'h00, 6);
    frame(8'h00, 8);

    // Long hold into lockout, release, press again.
    repeat (20) frame(8'h1A, 8);
    repeat (2) frame(8'h00, 8);
    repeat (2) frame(8'h2C, 8);
    repeat (2) frame(8'h00, 8);

    // Glitch shorter than the filter window, then a real press.
    repeat (3) cyc(8'h04, 1'b0);
    repeat (2) frame(8'h00, 8);
    repeat (2) frame(8'h04, 8);

    // Direction change mid-frame.
    repeat (3) cyc(8'h04, 1'b0);
    repeat (2) frame(8'h07, 8);
    frame(8'h00, 8);

    // Enter accepted on the very cycle of the tick.
    repeat (S) cyc(8'h28, 1'b0);
    cyc(8'h28, 1'b1);
    frame(8'h28, 8);
    frame(8'h00, 8);

    // Back-to-back ticks.
    repeat (3) cyc(8'h00, 1'b1);

    // Reset while a jump is held; key stays down across deassertion.
    repeat (3) frame(8'h2C, 8);
    rst = 1'b1;
    repeat (2) cyc(8'h2C, 1'b0);
    rst = 1'b0;
    repeat (4) frame(8'h2C, 3);
    frame(8'h00, 8);

    // Randomized key sequences with random tick spacing and rare resets.
    for (int n = 0; n < 400; n++) begin
      rk = key_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      for (int c = 0; c < int'($urandom_range(1, 10)); c++) begin
        cyc(rk, ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
        rst = 1'b0;
      end
    end
    repeat (4) cyc(8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keycode_input_ctrl.md
# keycode_input_ctrl

Downstream consumer of the SoC's 8-bit `keycode` export (USB HID keycode written by the NIOS USB driver). Filters transient keycode values, decodes Mario controls, and presents frame-latched button state plus a jump state machine (press pulse, hold duration, lockout) to the game logic. All outputs change only on `frame_tick`, so the game logic sees consistent inputs for a whole frame.

## Interface
- `STABLE_CYCLES`, 1024: consecutive identical cycles required before a keycode is accepted.
- `MAX_JUMP_FRAMES`, 16: frame count at which a held jump saturates and locks.
- `clk_clk`  in  1  system clock, same domain as the SoC.
- `reset_reset`  in  1  synchronous, active-high reset.
- `keycode`  in  8  raw HID keycode from the SoC export; 0x00 means no key.
- `frame_tick`  in  1  one-cycle pulse at start of vblank.
- `btn_left`, `btn_right`, `btn_down`  out  1 each  frame-latched held state.
- `jump_start`  out  1  high for exactly one frame on a new jump.
- `jump_hold`  out  1  jump is active and still held (variable jump height).
- `jump_frames`  out  $clog2(MAX_JUMP_FRAMES+1)  frames the current jump has been held.
- `pause_toggle`  out  1  high for one frame after an Enter press edge.
- `key_valid`  out  1  frame-latched: filtered code is nonzero.

## Operation
- **Filter:**
  - The stability counter resets to 0 whenever `keycode` differs from its previous-cycle value.
  - When the counter reaches `STABLE_CYCLES-1` with an unchanged input, `filt_code` takes the value of `keycode`.
  - The counter saturates and does not wrap.
- **Decode of `filt_code`:**
  - Left: 0x04 (A). Right: 0x07 (D). Down: 0x16 (S).
  - Jump: 0x1A (W) or 0x2C (Space).
  - Pause: 0x28 (Enter).
  - Any other code decodes to no button.
  - Only one key is active at a time, so left and right are never both set.
- **Sticky edge flags:**
  - `jump_edge_seen` sets on a jump press edge of the decoded signal.
  - `pause_edge_seen` sets on an Enter press edge.
  - Both flags clear on `frame_tick`.
  - A flag set in the same cycle as `frame_tick` counts for that tick.
- **Jump FSM** (`J_IDLE`, `J_HOLD`, `J_LOCK`), evaluated only on `frame_tick`:
  - **J_IDLE:**
    - Jump held, or edge seen → `J_HOLD`; `jump_start`=1, `jump_frames`=1, `jump_hold`=1.
    - If the edge was seen but the key is already released (tap between ticks): still `jump_start`=1, `jump_frames`=1, `jump_hold`=0, next state `J_IDLE`.
  - **J_HOLD:**
    - Jump still held → `jump_frames`+1, `jump_hold`=1.
    - When `jump_frames` reaches `MAX_JUMP_FRAMES` → `J_LOCK`.
    - Released → `J_IDLE`, `jump_frames`=0, `jump_hold`=0.
  - **J_LOCK:**
    - `jump_hold`=0, `jump_frames` holds at `MAX_JUMP_FRAMES`.
    - Release → `J_IDLE` with `jump_frames`=0. A new jump requires a release first.
  - `jump_start` is 0 on every tick other than the one that accepts a new jump.
- **Pause:** `pause_toggle` = `pause_edge_seen` at tick, latched for one frame.

## Timing
- **Reset values:**
  - All outputs 0.
  - `filt_code`=0x00, counter 0, FSM `J_IDLE`, sticky flags 0.
- **Reset mid-operation** aborts any jump; no `jump_start` is generated for a key still held at deassertion until the filter re-accepts it.
- **Filter latency:** a keycode change is visible in `filt_code` `STABLE_CYCLES` cycles after it first appears on `keycode`.
- **Output latency:** outputs update on the cycle after `frame_tick` (registered). Between ticks they are constant.
- **Back-to-back `frame_tick`s** are legal; each is a full evaluation.
- **Glitch rejection:** a keycode value lasting fewer than `STABLE_CYCLES` cycles produces no output change.

## Structure
- **Package `keycode_pkg`:**
  - HID constants `KC_A`, `KC_D`, `KC_S`, `KC_W`, `KC_SPACE`, `KC_ENTER`.
  - Enum `jump_state_t`.
- **Sub-module `keycode_filter`:** stability counter plus `filt_code` register, parameterized by `STABLE_CYCLES`.
- **Top `keycode_input_ctrl`:** decode, edge flags, FSM, and frame latches.

## Test plan
- **Tap:** with `STABLE_CYCLES`=4, drive 0x2C for 10 cycles then 0x00, all between two ticks → one frame with `jump_start`=1, `jump_frames`=1, `jump_hold`=0; next frame all 0.
- **Hold jump:** hold 0x1A for 20 frames with `MAX_JUMP_FRAMES`=16.
  - `jump_frames` reads 1..16, `jump_hold`=1 through frame 15.
  - Frame 16 and later: `J_LOCK`, `jump_hold`=0, `jump_frames`=16, no new `jump_start`.
  - After release, the next press gives `jump_start`=1.
- **Glitch:** keycode 0x04 for 3 cycles with `STABLE_CYCLES`=4 → `btn_left` stays 0. Held for 4 or more cycles → `btn_left`=1 after the next tick.
- **Direction change:** 0x04 → 0x07 mid-frame → `btn_left`/`btn_right` swap only after the next tick, never both 1.
- **Simultaneous:** Enter's filtered edge lands on the same cycle as `frame_tick` → `pause_toggle`=1 for that frame only.
- **Reset:** assert `reset_reset` during `J_HOLD` with 0x2C held → all outputs 0. After deassertion, `jump_start`=1 only at the first tick following filter acceptance.
